// File: rtl/iter_shift.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/ROL/ROR applied STEP bits per clock.
// A small IDLE/RUN/DONE FSM sequences the work; result and carry update only on completion.
module iter_shift #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src,
   input  logic [WIDTH-1:0] dst,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0]     OP_SLL = 3'd0;
   localparam logic [2:0]     OP_SRL = 3'd1;
   localparam logic [2:0]     OP_SRA = 3'd2;
   localparam logic [2:0]     OP_ROL = 3'd3;
   localparam logic [2:0]     OP_ROR = 3'd4;
   localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

   state_t           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   rem;

   logic [SHW-1:0]   n_in;
   logic             pass_in;
   logic [SHW-1:0]   k;
   logic [SHW-1:0]   k_inv;
   logic [WIDTH-1:0] step_val;
   logic             step_cf;
   logic             unused_src_hi;

   assign n_in          = src[SHW-1:0];
   assign pass_in       = (op > OP_ROR);
   assign unused_src_hi = ^src[WIDTH-1:SHW];

   // One step of the shift: k bits this cycle, plus the bit that leaves the word last.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path
      // leaves it unassigned; an unassigned path would infer a latch.
      step_val = work;
      step_cf  = 1'b0;
      k        = (rem > STEP_K) ? STEP_K : rem;
      // WIDTH is 2**SHW, so the modular negation is exactly WIDTH-k for k>0.
      k_inv    = -k;
      case (op_q)
         OP_SLL: begin
            step_val = work << k;
            step_cf  = work[k_inv];
         end
         OP_SRL: begin
            step_val = work >> k;
            step_cf  = work[k - 1'b1];
         end
         OP_SRA: begin
            step_val = unsigned'($signed(work) >>> k);
            step_cf  = work[k - 1'b1];
         end
         OP_ROL: begin
            step_val = (work << k) | (work >> k_inv);
            step_cf  = step_val[0];
         end
         OP_ROR: begin
            step_val = (work >> k) | (work << k_inv);
            step_cf  = step_val[WIDTH-1];
         end
         default: begin
            step_val = work;
            step_cf  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= 3'd0;
         work   <= '0;
         rem    <= '0;
         result <= '0;
         cf     <= 1'b0;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (flush) begin
         // Abort wins over any request; result and cf keep the last completed value.
         state <= IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_q <= op;
                  work <= dst;
                  rem  <= n_in;
                  if (n_in == '0 || pass_in) begin
                     state  <= DONE;
                     result <= dst;
                     cf     <= 1'b0;
                     ready  <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     state <= RUN;
                     ready <= 1'b0;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               work <= step_val;
               rem  <= rem - k;
               if (rem == k) begin
                  state  <= DONE;
                  result <= step_val;
                  cf     <= step_cf;
                  ready  <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift.sv
// Bench for iter_shift: directed scenarios plus random ops, scored against a
// whole-amount shift model with predicted done latency.
module tb_iter_shift;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;
   localparam int STEP  = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op    = 3'd0;
   logic [31:0] src   = '0;
   logic [31:0] dst   = '0;
   logic        ready, busy, done, cf;
   logic [31:0] result;

   iter_shift #(.WIDTH(WIDTH), .SHW(SHW), .STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
      .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result), .cf(cf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        cf;
      int          done_edge;
   } exp_t;

   exp_t        sb[$];
   int          total    = 0;
   int          bad      = 0;
   int          edge_cnt = 0;
   int          busy_end = 0;
   logic [31:0] last_res = '0;
   logic        last_cf  = 1'b0;
   bit          exp_done, exp_busy;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (edge %0d)", name, got, exp, edge_cnt);
      end
   endtask

   // Reference: apply the full shift amount in one go.
   function automatic void model(input logic [2:0] o, input logic [31:0] d, input int n,
                                 output logic [31:0] r, output logic c);
      r = d;
      c = 1'b0;
      if (n != 0) begin
         case (o)
            3'd0: begin r = d << n;                       c = d[32-n]; end
            3'd1: begin r = d >> n;                       c = d[n-1];  end
            3'd2: begin r = unsigned'($signed(d) >>> n);  c = d[n-1];  end
            3'd3: begin r = (d << n) | (d >> (32 - n));   c = r[0];    end
            3'd4: begin r = (d >> n) | (d << (32 - n));   c = r[31];   end
            default: begin r = d; c = 1'b0; end
         endcase
      end
   endfunction

   // Drive one cycle of inputs and predict what the next edge does.
   task automatic issue(input bit s, input logic [2:0] o, input logic [31:0] sr,
                        input logic [31:0] d, input bit f, output bit acc);
      exp_t        it;
      logic [31:0] r;
      logic        c;
      int          e, n, lat;
      @(negedge clk);
      start = s; op = o; src = sr; dst = d; flush = f;
      e   = edge_cnt + 1;
      acc = 1'b0;
      if (f) begin
         while (sb.size() > 0 && sb[sb.size()-1].done_edge >= e) sb.delete(sb.size()-1);
         busy_end = e;
      end else if (s && e > busy_end) begin
         n = int'(sr[4:0]);
         model(o, d, n, r, c);
         lat = (n == 0 || o > 3'd4) ? 0 : (n + STEP - 1) / STEP;
         it.res       = r;
         it.cf        = c;
         it.done_edge = e + lat;
         busy_end     = e + lat;
         sb.push_back(it);
         acc = 1'b1;
      end
   endtask

   task automatic idle(input int cycles);
      bit a;
      for (int i = 0; i < cycles; i++) issue(1'b0, 3'd0, '0, '0, 1'b0, a);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() > 0 && w < 60) begin
         idle(1);
         w++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   // Monitor: compare done/result/cf/busy/ready just after every edge.
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt++;
         #1;
         exp_done = (sb.size() > 0) && (sb[0].done_edge == edge_cnt);
         check("done", done, exp_done);
         if (exp_done) begin
            if (done) begin
               check("result", result, sb[0].res);
               check("cf", cf, sb[0].cf);
               last_res = result;
               last_cf  = cf;
            end
            sb.delete(0);
         end
         exp_busy = (sb.size() > 0) && (sb[0].done_edge > edge_cnt);
         check("busy", busy, exp_busy);
         check("ready", ready, !exp_busy);
      end
   end

   initial begin
      bit a;
      int acc_cnt, guard;
      bit          rs, rf;
      logic [2:0]  ro;
      logic [31:0] rsrc, rdst;

      #1 rst_n = 1'b0;
      #1;
      check("rst_result", result, 32'h0);
      check("rst_cf", cf, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      busy_end = edge_cnt;

      // SLL by 1
      issue(1'b1, 3'd0, 32'd1, 32'h8000_0001, 1'b0, a);
      drain();
      check("sll1_res", last_res, 32'h0000_0002);
      check("sll1_cf", last_cf, 1);

      // SRA by 5
      issue(1'b1, 3'd2, 32'd5, 32'h8000_0010, 1'b0, a);
      drain();
      check("sra5_res", last_res, 32'hFC00_0000);
      check("sra5_cf", last_cf, 1);

      // ROR by 8, then a zero-length SRL issued back-to-back in DONE
      issue(1'b1, 3'd4, 32'd8, 32'h0000_00F1, 1'b0, a);
      idle(2);
      issue(1'b1, 3'd1, 32'd0, 32'h1234_5678, 1'b0, a);
      check("b2b_accepted", a, 1);
      check("ror8_done", done, 1);
      check("ror8_res", result, 32'hF100_0000);
      check("ror8_cf", cf, 1);
      drain();
      check("srl0_res", last_res, 32'h1234_5678);
      check("srl0_cf", last_cf, 0);

      // SLL by 31 flushed in its third RUN cycle
      issue(1'b1, 3'd0, 32'd31, 32'hDEAD_BEEF, 1'b0, a);
      idle(2);
      issue(1'b1, 3'd1, 32'd3, 32'hFFFF_FFFF, 1'b1, a);
      idle(1);
      check("flush_ready", ready, 1);
      check("flush_hold_res", result, 32'h1234_5678);
      check("flush_hold_cf", cf, 0);
      idle(8);
      issue(1'b1, 3'd1, 32'd4, 32'hF000_0000, 1'b0, a);
      drain();
      check("srl4_res", last_res, 32'h0F00_0000);
      check("srl4_cf", last_cf, 0);

      // Asynchronous reset in the middle of a RUN
      issue(1'b1, 3'd3, 32'd20, 32'hA5A5_0F0F, 1'b0, a);
      idle(1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_result", result, 32'h0);
      check("arst_cf", cf, 0);
      check("arst_done", done, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", ready, 1);
      sb.delete();
      #1 rst_n = 1'b1;
      busy_end = edge_cnt;
      idle(8);

      // Random ops with random start, flush and back-to-back requests
      acc_cnt = 0;
      guard   = 0;
      while (acc_cnt < 1000 && guard < 40000) begin
         rs   = ($urandom_range(0, 99) < 60);
         rf   = ($urandom_range(0, 99) < 4);
         ro   = 3'($urandom_range(0, 7));
         rsrc = $urandom;
         rdst = $urandom;
         issue(rs, ro, rsrc, rdst, rf, a);
         if (a) acc_cnt++;
         guard++;
      end
      check("rand_accepts", acc_cnt, 1000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
